// File: rtl/data_memory_wait.sv
// data_memory_wait: word-organised data memory with a fixed multi-cycle access time.
//
// A request (read or write; byte, half or word) raises BUSYWAIT in the same cycle
// and keeps it high for exactly LATENCY cycles. The access completes on the last
// stalled edge. The following DONE cycle shows the load result on READDATA, or
// ERROR for a misaligned request. The FSM then returns to IDLE.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 4..4096)
//   LATENCY      BUSYWAIT cycles per access (1..15)
// Ports
//   CLK            clock, rising edge
//   RESET          synchronous active-high reset; also clears the whole array
//   READ_WRITE_EN  [3:2] op (01 read, 10 write, else idle); [1:0] size (00 byte, 01 half, 1x word)
//   ADDRESS        byte address; bits above the word index are ignored
//   WRITEDATA      right-aligned store data
//   READDATA       right-aligned, zero-extended load data, held until the next access completes
//   BUSYWAIT       stall request to the CPU
//   ERROR          one-cycle misaligned-access flag, high in the DONE cycle
module data_memory_wait #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ_WRITE_EN,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        ERROR
);

    localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LatLoad = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              wr_q;
    logic [31:0]       wdata_q;
    logic              after_rst_q;
    logic [31:0]       rdata_q;
    logic              error_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              req_rd, req_wr, accept, do_access;
    logic [IdxW-1:0]   acc_idx;
    logic [1:0]        acc_off, acc_size;
    logic              acc_wr;
    logic [31:0]       acc_wdata;
    logic              misaligned;
    logic [3:0]        wmask;
    logic [31:0]       wword, rword, rshift, rresult;
    logic              unused_addr;

    assign unused_addr = ^ADDRESS[31:IdxW+2];

    assign req_rd = (READ_WRITE_EN[3:2] == 2'b01);
    assign req_wr = (READ_WRITE_EN[3:2] == 2'b10);
    // The cycle right after reset never starts an access, so BUSYWAIT stays low there.
    assign accept = (state_q == StIdle) && (req_rd || req_wr) && !after_rst_q && !RESET;

    // With LATENCY=1 the access completes at the edge leaving IDLE, so the
    // operands come straight from the inputs; otherwise from the sampled copy.
    always_comb begin
        if (state_q == StIdle) begin
            acc_idx   = ADDRESS[IdxW+1:2];
            acc_off   = ADDRESS[1:0];
            acc_size  = READ_WRITE_EN[1:0];
            acc_wr    = req_wr;
            acc_wdata = WRITEDATA;
        end else begin
            acc_idx   = idx_q;
            acc_off   = off_q;
            acc_size  = size_q;
            acc_wr    = wr_q;
            acc_wdata = wdata_q;
        end
    end

    // FSM next state. cnt_q holds the number of WAIT cycles still to go; the
    // IDLE request cycle is the first stalled cycle, so BUSYWAIT totals LATENCY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        BUSYWAIT  = 1'b0;
        do_access = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    BUSYWAIT = 1'b1;
                    if (LATENCY <= 1) begin
                        do_access = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = StDone;
                    end else begin
                        cnt_d   = LatLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                BUSYWAIT = 1'b1;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    do_access = 1'b1;
                    cnt_d     = 4'd0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                // Any request presented here is ignored.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Lane selection and load alignment.
    always_comb begin
        misaligned = ((acc_size == 2'b01) && acc_off[0]) ||
                     (acc_size[1] && (acc_off != 2'b00));
        rword      = mem_q[acc_idx];
        rshift     = rword >> {acc_off, 3'b000};
        wmask      = 4'b0000;
        wword      = acc_wdata;
        rresult    = rword;
        case (acc_size)
            2'b00: begin
                wmask   = 4'b0001 << acc_off;
                wword   = {4{acc_wdata[7:0]}};
                rresult = {24'h0, rshift[7:0]};
            end
            2'b01: begin
                wmask   = acc_off[1] ? 4'b1100 : 4'b0011;
                wword   = {2{acc_wdata[15:0]}};
                rresult = {16'h0, (acc_off[1] ? rword[31:16] : rword[15:0])};
            end
            default: begin
                wmask   = 4'b1111;
                wword   = acc_wdata;
                rresult = rword;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            wr_q        <= 1'b0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            error_q     <= 1'b0;
            after_rst_q <= 1'b1;
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            after_rst_q <= 1'b0;
            if (accept) begin
                idx_q   <= ADDRESS[IdxW+1:2];
                off_q   <= ADDRESS[1:0];
                size_q  <= READ_WRITE_EN[1:0];
                wr_q    <= req_wr;
                wdata_q <= WRITEDATA;
            end
            if (do_access) begin
                if (misaligned) begin
                    rdata_q <= 32'h0;
                    error_q <= 1'b1;
                end else begin
                    error_q <= 1'b0;
                    if (acc_wr) begin
                        rdata_q <= 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (wmask[b]) begin
                                mem_q[acc_idx][b*8 +: 8] <= wword[b*8 +: 8];
                            end
                        end
                    end else begin
                        rdata_q <= rresult;
                    end
                end
            end else if (state_q == StDone) begin
                error_q <= 1'b0;
            end
        end
    end

    assign READDATA = rdata_q;
    assign ERROR    = error_q;

endmodule

// File: tb/tb_data_memory_wait.sv
// Scoreboard bench for data_memory_wait: the driver pushes hand-computed
// expectations, a monitor pops them at each completed access. Two extra
// instances (LATENCY 1 and 15) are run with a held read request to measure
// stall length and the gap between back-to-back accesses.
module tb_data_memory_wait;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rwe;
    logic [31:0] addr, wdata, rdata;
    logic        busy, err;

    logic [3:0]  sw_rwe;
    logic [31:0] sw_addr, sw_wdata;
    logic [31:0] rd1, rd15;
    logic        bw1, bw15, er1, er15;
    logic        sw_on = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       name;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    data_memory_wait #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .CLK(clk), .RESET(rst), .READ_WRITE_EN(rwe), .ADDRESS(addr),
        .WRITEDATA(wdata), .READDATA(rdata), .BUSYWAIT(busy), .ERROR(err)
    );

    data_memory_wait #(.DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
        .CLK(clk), .RESET(rst), .READ_WRITE_EN(sw_rwe), .ADDRESS(sw_addr),
        .WRITEDATA(sw_wdata), .READDATA(rd1), .BUSYWAIT(bw1), .ERROR(er1)
    );

    data_memory_wait #(.DEPTH_WORDS(16), .LATENCY(15)) u_l15 (
        .CLK(clk), .RESET(rst), .READ_WRITE_EN(sw_rwe), .ADDRESS(sw_addr),
        .WRITEDATA(sw_wdata), .READDATA(rd15), .BUSYWAIT(bw15), .ERROR(er15)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Main monitor: a falling BUSYWAIT not caused by reset marks the DONE cycle.
    logic prev_busy = 1'b0;
    logic rst_prev  = 1'b1;
    int   run       = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            run++;
            check("error_low_while_busy", {31'h0, err}, 32'h0);
        end else begin
            if (prev_busy && !rst_prev) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got access, expected none");
                end else begin
                    e = sbq.pop_front();
                    check({e.name, "_rdata"}, rdata, e.rd);
                    check({e.name, "_error"}, {31'h0, err}, {31'h0, e.err});
                    check({e.name, "_busy_len"}, 32'(run), 32'd2);
                end
            end
            run = 0;
        end
        prev_busy = busy;
        rst_prev  = rst;
    end

    // Sweep monitors: every stall lasts LATENCY cycles, every gap is one cycle.
    logic p1 = 1'b0, p15 = 1'b0, s1 = 1'b0, s15 = 1'b0;
    int   r1 = 0, g1 = 0, r15 = 0, g15 = 0;
    always @(negedge clk) begin
        if (sw_on) begin
            if (bw1) begin
                if (!p1 && s1) check("l1_gap", 32'(g1), 32'd1);
                r1++;
                g1 = 0;
            end else begin
                if (p1) begin
                    check("l1_busy_len", 32'(r1), 32'd1);
                    s1 = 1'b1;
                    r1 = 0;
                end
                g1++;
            end
            if (bw15) begin
                if (!p15 && s15) check("l15_gap", 32'(g15), 32'd1);
                r15++;
                g15 = 0;
            end else begin
                if (p15) begin
                    check("l15_busy_len", 32'(r15), 32'd15);
                    s15 = 1'b1;
                    r15 = 0;
                end
                g15++;
            end
            p1  = bw1;
            p15 = bw15;
        end
    end

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got busy for 40 cycles, expected done", name);
        end
    endtask

    // One access; inputs are scrambled during WAIT to show they are not re-sampled.
    task automatic access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        sbq.push_back('{exp_rd, exp_err, name});
        rwe   = op;
        addr  = a;
        wdata = d;
        @(posedge clk); #1;
        rwe   = 4'b1010;
        addr  = 32'h20;
        wdata = 32'hFFFF_FFFF;
        wait_done(name);
        rwe   = 4'b0000;
        addr  = 32'h0;
        wdata = 32'h0;
        @(negedge clk);
        check({name, "_hold"}, rdata, exp_rd);
        check({name, "_err_clear"}, {31'h0, err}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rwe = 4'b0100; addr = 32'h0; wdata = 32'h0;
        sw_rwe = 4'b0000; sw_addr = 32'h0; sw_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_error", {31'h0, err}, 32'h0);
        check("reset_busy_priority", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rwe = 4'b1100;
        @(negedge clk);
        check("op11_idle_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rwe = 4'b0000;

        access(4'b1010, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0, "wr_w10");
        access(4'b0110, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0, "rd_w10");
        access(4'b1010, 32'h20,  32'h1122_3344, 32'h0,         1'b0, "wr_w20");
        access(4'b1000, 32'h21,  32'hFFFF_FFAA, 32'h0,         1'b0, "wr_b21");
        access(4'b1001, 32'h22,  32'h1234_5566, 32'h0,         1'b0, "wr_h22");
        access(4'b0110, 32'h20,  32'h0,         32'h5566_AA44, 1'b0, "rd_w20");
        access(4'b0100, 32'h23,  32'h0,         32'h0000_0055, 1'b0, "rd_b23");
        access(4'b0110, 32'h22,  32'h0,         32'h0,         1'b1, "rd_w22_mis");
        access(4'b0110, 32'h20,  32'h0,         32'h5566_AA44, 1'b0, "rd_w20_again");
        access(4'b0101, 32'h22,  32'h0,         32'h0000_5566, 1'b0, "rd_h22");
        access(4'b0101, 32'h20,  32'h0,         32'h0000_AA44, 1'b0, "rd_h20");
        access(4'b0100, 32'h21,  32'h0,         32'h0000_00AA, 1'b0, "rd_b21");
        access(4'b1001, 32'h21,  32'h0000_BEEF, 32'h0,         1'b1, "wr_h21_mis");
        access(4'b0101, 32'h21,  32'h0,         32'h0,         1'b1, "rd_h21_mis");
        access(4'b1010, 32'h26,  32'h0BAD_0BAD, 32'h0,         1'b1, "wr_w26_mis");
        access(4'b0110, 32'h20,  32'h0,         32'h5566_AA44, 1'b0, "rd_w20_intact");
        access(4'b1010, 32'h400, 32'h1234_5678, 32'h0,         1'b0, "wr_w400");
        access(4'b0110, 32'h000, 32'h0,         32'h1234_5678, 1'b0, "rd_w000_wrap");
        access(4'b1011, 32'h40,  32'hCAFE_F00D, 32'h0,         1'b0, "wr_w40_sz11");
        access(4'b0111, 32'h40,  32'h0,         32'hCAFE_F00D, 1'b0, "rd_w40_sz11");

        // Back-to-back: request held, second read starts in the cycle after DONE.
        sbq.push_back('{32'h5566_AA44, 1'b0, "b2b_first"});
        sbq.push_back('{32'hDEAD_BEEF, 1'b0, "b2b_second"});
        rwe = 4'b0110; addr = 32'h20;
        @(posedge clk); #1;
        addr = 32'h10;
        wait_done("b2b_first");
        @(negedge clk);
        check("b2b_rearm_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        rwe = 4'b0000; addr = 32'h0;
        wait_done("b2b_second");
        @(posedge clk); #1;

        // Reset in WAIT aborts the write and clears the array.
        rwe = 4'b1010; addr = 32'h30; wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst = 1'b1; rwe = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0; rwe = 4'b0110; addr = 32'h30;
        @(negedge clk);
        check("abort_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        access(4'b0110, 32'h30, 32'h0, 32'h0, 1'b0, "rd_w30_after_abort");
        access(4'b0110, 32'h10, 32'h0, 32'h0, 1'b0, "rd_w10_cleared");
        access(4'b0110, 32'h00, 32'h0, 32'h0, 1'b0, "rd_w00_cleared");

        // Latency sweep with a continuously held read.
        sw_on  = 1'b1;
        sw_rwe = 4'b0110;
        repeat (70) @(posedge clk);
        #1;
        sw_rwe = 4'b0000;
        repeat (20) @(posedge clk);
        #1;
        sw_on = 1'b0;

        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
